// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with almost thresholds, sticky error flags,
// synchronous flush and selectable registered or first-word-fall-through read.
module sync_fifo_flex #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_mem_empty;
    logic w_mem_we;
    logic w_rd_adv;
    logic w_load_mem;
    logic w_load_din;

    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);

    // Accept/steer decode; in FWFT mode the output register holds the head word,
    // so memory never holds more than DEPTH-1 words and equal pointers mean empty.
    always_comb begin
        w_wr_ok    = wr_en && !w_full && !clr;
        w_rd_ok    = rd_en && !w_empty && !clr;
        w_mem_we   = 1'b0;
        w_rd_adv   = 1'b0;
        w_load_mem = 1'b0;
        w_load_din = 1'b0;
        if (FWFT != 0) begin
            if (w_empty) begin
                w_load_din = w_wr_ok;
            end else if (w_rd_ok) begin
                if (w_mem_empty) begin
                    w_load_din = w_wr_ok;
                end else begin
                    w_load_mem = 1'b1;
                    w_rd_adv   = 1'b1;
                    w_mem_we   = w_wr_ok;
                end
            end else begin
                w_mem_we = w_wr_ok;
            end
        end else begin
            w_mem_we   = w_wr_ok;
            w_rd_adv   = w_rd_ok;
            w_load_mem = w_rd_ok;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_ptr] <= din;
    end

    // Pointers, occupancy, output register and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dout      <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dout      <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_mem_we) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_adv) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_load_mem) begin
                r_dout <= r_mem[r_rd_ptr];
            end else if (w_load_din) begin
                r_dout <= din;
            end
            r_rd_valid <= w_rd_ok;
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    assign dout         = r_dout;
    assign rd_valid     = (FWFT != 0) ? !w_empty : r_rd_valid;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= AE_C);
    assign almost_full  = (r_count >= AF_C);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: one registered-read instance and one FWFT instance; expected
// read data is queued at stimulus time and consumed by per-instance monitors.
module tb_sync_fifo_flex;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr0 = 1'b0, wr_en0 = 1'b0, rd_en0 = 1'b0;
    logic [7:0] din0 = 8'h00;
    logic       clr1 = 1'b0, wr_en1 = 1'b0, rd_en1 = 1'b0;
    logic [7:0] din1 = 8'h00;
    logic [7:0] dout0, dout1;
    logic       rd_valid0, empty0, full0, ae0, af0, ovf0, udf0;
    logic       rd_valid1, empty1, full1, ae1, af1, ovf1, udf1;
    logic [4:0] count0, count1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .wr_en(wr_en0), .din(din0), .rd_en(rd_en0),
        .dout(dout0), .rd_valid(rd_valid0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(count0),
        .overflow(ovf0), .underflow(udf0));

    sync_fifo_flex #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .wr_en(wr_en1), .din(din1), .rd_en(rd_en1),
        .dout(dout1), .rd_valid(rd_valid1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(count1),
        .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step0(input logic wr, input logic [7:0] d, input logic rd);
        wr_en0 = wr; din0 = d; rd_en0 = rd;
        @(posedge clk); #1;
        wr_en0 = 1'b0; rd_en0 = 1'b0;
    endtask

    task automatic step1(input logic wr, input logic [7:0] d, input logic rd);
        wr_en1 = wr; din1 = d; rd_en1 = rd;
        @(posedge clk); #1;
        wr_en1 = 1'b0; rd_en1 = 1'b0;
    endtask

    // Registered-read monitor: one expected word per rd_valid cycle.
    always @(negedge clk) begin
        if (rd_valid0) begin
            if (exp0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd0_unexpected: got rd_valid with dout %0h expected no read", dout0);
            end else begin
                chk("rd0_data", dout0, exp0.pop_front());
            end
        end
    end

    // FWFT monitor: the head word is checked when it is popped.
    always @(negedge clk) begin
        if (rd_en1 && !empty1) begin
            if (exp1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd1_unexpected: got pop of %0h expected no pop", dout1);
            end else begin
                chk("rd1_data", dout1, exp1.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", dout0, 8'h00);
        chk("rst_flags", {rd_valid0, empty0, full0, ae0, af0, ovf0, udf0}, 7'b0101000);
        chk("rst_count", count0, 5'd0);
        chk("rst_fwft", {empty1, rd_valid1, count1}, {1'b1, 1'b0, 5'd0});
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            step0(1'b1, 8'(i), 1'b0);
            chk("t1_af", af0, (i >= 12) ? 1 : 0);
            chk("t1_ae", ae0, (i <= 2) ? 1 : 0);
        end
        chk("t1_full", full0, 1'b1);
        chk("t1_count", count0, 5'd16);
        step0(1'b1, 8'hFF, 1'b0);
        chk("t1_ovf", ovf0, 1'b1);
        chk("t1_count_ovf", count0, 5'd16);
        for (int i = 1; i <= 16; i++) begin
            exp0.push_back(8'(i));
            step0(1'b0, 8'h00, 1'b1);
        end
        step0(1'b0, 8'h00, 1'b0);
        chk("t1_empty", {empty0, count0, rd_valid0}, {1'b1, 5'd0, 1'b0});

        // T2: underflow on empty, clr clears sticky flags
        step0(1'b0, 8'h00, 1'b1);
        chk("t2_udf", udf0, 1'b1);
        chk("t2_dout_hold", dout0, 8'h10);
        chk("t2_count", count0, 5'd0);
        chk("t2_no_valid", rd_valid0, 1'b0);
        chk("t2_ovf_sticky", ovf0, 1'b1);
        clr0 = 1'b1; step0(1'b0, 8'h00, 1'b0); clr0 = 1'b0;
        chk("t2_clr", {udf0, ovf0, dout0}, {1'b0, 1'b0, 8'h00});

        // T3: steady count 3 across pointer wrap
        for (int i = 0; i < 3; i++) step0(1'b1, 8'h20 + 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp0.push_back(8'h20 + 8'(i));
            step0(1'b1, 8'h23 + 8'(i), 1'b1);
            chk("t3_count", count0, 5'd3);
            chk("t3_ae", ae0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            exp0.push_back(8'h48 + 8'(i));
            step0(1'b0, 8'h00, 1'b1);
        end
        chk("t3_drained", count0, 5'd0);

        // T4: simultaneous wr+rd at 5, then at full
        for (int i = 0; i < 5; i++) step0(1'b1, 8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp0.push_back(8'h60 + 8'(i));
            step0(1'b1, 8'h65 + 8'(i), 1'b1);
            chk("t4_count5", count0, 5'd5);
        end
        for (int i = 0; i < 11; i++) step0(1'b1, 8'h6F + 8'(i), 1'b0);
        chk("t4_full", {full0, ovf0}, {1'b1, 1'b0});
        exp0.push_back(8'h6A);
        step0(1'b1, 8'hEE, 1'b1);
        chk("t4_full_wrrd", {count0, ovf0}, {5'd15, 1'b1});
        for (int i = 0; i < 15; i++) begin
            exp0.push_back(8'h6B + 8'(i));
            step0(1'b0, 8'h00, 1'b1);
        end
        chk("t4_drained", count0, 5'd0);

        // T5: FWFT bypass, pops without bubbles, full/overflow
        step1(1'b1, 8'hA5, 1'b0);
        chk("t5_bypass", {dout1, empty1, count1, rd_valid1}, {8'hA5, 1'b0, 5'd1, 1'b1});
        exp1.push_back(8'hA5);
        step1(1'b0, 8'h00, 1'b1);
        chk("t5_empty", {empty1, rd_valid1}, 2'b10);
        for (int i = 1; i <= 4; i++) step1(1'b1, 8'(i), 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("t5_no_bubble", empty1, 1'b0);
            exp1.push_back(8'(i));
            step1(1'b0, 8'h00, 1'b1);
        end
        chk("t5_empty2", empty1, 1'b1);
        step1(1'b1, 8'h10, 1'b0);
        exp1.push_back(8'h10);
        step1(1'b1, 8'h11, 1'b1);
        chk("t5_wrrd_one", {dout1, count1}, {8'h11, 5'd1});
        exp1.push_back(8'h11);
        step1(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) step1(1'b1, 8'h80 + 8'(i), 1'b0);
        chk("t5_full", {full1, count1, af1, dout1}, {1'b1, 5'd16, 1'b1, 8'h80});
        step1(1'b1, 8'hFF, 1'b0);
        chk("t5_ovf", {ovf1, count1}, {1'b1, 5'd16});
        for (int i = 0; i < 16; i++) begin
            exp1.push_back(8'h80 + 8'(i));
            step1(1'b0, 8'h00, 1'b1);
        end
        chk("t5_drained", {empty1, count1}, {1'b1, 5'd0});
        step1(1'b0, 8'h00, 1'b1);
        chk("t5_udf", udf1, 1'b1);

        // T6: clr at count 9 (requests ignored), then async reset mid-write
        for (int i = 0; i < 9; i++) step0(1'b1, 8'h30 + 8'(i), 1'b0);
        chk("t6_count9", count0, 5'd9);
        clr0 = 1'b1; step0(1'b1, 8'hDD, 1'b1); clr0 = 1'b0;
        chk("t6_clr", {count0, empty0, dout0, ovf0, udf0}, {5'd0, 1'b1, 8'h00, 1'b0, 1'b0});
        chk("t6_clr_rv", rd_valid0, 1'b0);
        for (int i = 0; i < 5; i++) step0(1'b1, 8'h40 + 8'(i), 1'b0);
        step1(1'b1, 8'h77, 1'b0);
        wr_en0 = 1'b1; din0 = 8'h45;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst0", {count0, empty0, full0, ae0, af0, ovf0, udf0, rd_valid0, dout0},
            {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        chk("t6_rst1", {count1, empty1, dout1, ovf1, udf1}, {5'd0, 1'b1, 8'h00, 1'b0, 1'b0});
        wr_en0 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_rst", count0, 5'd0);
        step0(1'b1, 8'h50, 1'b0);
        exp0.push_back(8'h50);
        step0(1'b0, 8'h00, 1'b1);
        step0(1'b0, 8'h00, 1'b0);
        chk("t6_final0", {count0, empty0}, {5'd0, 1'b1});
        step1(1'b1, 8'h88, 1'b0);
        chk("t6_fwft_new", {dout1, count1}, {8'h88, 5'd1});
        exp1.push_back(8'h88);
        step1(1'b0, 8'h00, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("exp0_left", exp0.size(), 0);
        chk("exp1_left", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
